// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop input synchronizer, mid-bit sampling,
// sticky byte_ready/overrun flags cleared by the consumer, and a framing-error pulse.
module uart_rx #(
  parameter int clock_frequency = 12000000,
  parameter int usart_baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       uart_clear,
  output logic [7:0] rx_byte,      // last received data byte
  output logic       byte_ready,
  output logic       framing_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int DIV   = clock_frequency / usart_baud_rate;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV/2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t           r_state, w_next;
  logic             r_sync1, r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_byte;
  logic             r_ready, r_ferr, r_ovr;

  logic w_rxs, w_tick, w_load_half, w_start_ok, w_shift, w_done, w_ferr;

  assign w_rxs  = r_sync2;
  assign w_tick = (r_cnt == '0);

  // Two-flop synchronizer; flops reset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and per-cycle control strobes; only sample points (w_tick) advance the frame.
  always_comb begin
    w_next      = r_state;
    w_load_half = 1'b0;
    w_start_ok  = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_next      = S_START;
          w_load_half = 1'b1;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (!w_rxs) begin
            w_next     = S_DATA;
            w_start_ok = 1'b1;
          end else begin
            w_next = S_IDLE;   // false start, silently dropped
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift = 1'b1;
          if (r_bit_idx == 3'd7) w_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (w_rxs) begin
            w_done = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_ferr = 1'b1;
            w_next = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        // A held-low line (break) parks here until it returns high.
        if (w_rxs) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Baud counter: half-bit load on the start edge, full-bit reload after each sample point.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_load_half) begin
      r_cnt <= CNT_HALF;
    end else if (r_state == S_START || r_state == S_DATA || r_state == S_STOP) begin
      r_cnt <= w_tick ? CNT_FULL : r_cnt - 1'b1;
    end
  end

  // Bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (w_start_ok) r_bit_idx <= '0;
      else if (w_shift) r_bit_idx <= r_bit_idx + 3'd1;
      if (w_shift) r_shift <= {w_rxs, r_shift[7:1]};
    end
  end

  // Consumer-facing flags; a completing byte always beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte  <= '0;
      r_ready <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      if (w_done) begin
        r_byte  <= r_shift;
        r_ready <= 1'b1;
        if (uart_clear)   r_ovr <= 1'b0;
        else if (r_ready) r_ovr <= 1'b1;
      end else if (uart_clear) begin
        r_ready <= 1'b0;
        r_ovr   <= 1'b0;
      end
    end
  end

  assign rx_byte     = r_byte;
  assign byte_ready  = r_ready;
  assign framing_err = r_ferr;
  assign overrun     = r_ovr;
  assign rx_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames at DIV=16; expected bytes go into a scoreboard queue,
// a negedge monitor pops and compares whenever a new byte appears on the outputs.
module tb_uart_rx;

  localparam int DIV = 16;
  localparam int LAT = DIV/2 + 9*DIV + 3;   // 155 cycles start edge -> byte_ready

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       uart_clear = 1'b0;
  logic [7:0] rx_byte;
  logic       byte_ready, framing_err, overrun, rx_busy;

  typedef struct {
    logic [7:0] b;
    logic       ovr;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_ferr  = 0;
  int   cyc     = 0;
  int   t_start = 0;
  int   lat;
  logic       p_ready = 1'b0;
  logic [7:0] p_byte  = 8'h00;

  uart_rx #(.clock_frequency(16), .usart_baud_rate(1)) dut (
    .clk(clk), .rst(rst), .rx(rx), .uart_clear(uart_clear),
    .rx_byte(rx_byte), .byte_ready(byte_ready), .framing_err(framing_err),
    .overrun(overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Start bit, 8 data bits LSB first, stop bit; the line is left at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(posedge clk); #1 rx = 1'b0; t_start = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(posedge clk);
      #1 rx = d[i];
    end
    repeat (DIV) @(posedge clk);
    #1 rx = stop;
    repeat (DIV) @(posedge clk);
  endtask

  task automatic push(input logic [7:0] b, input logic ovr);
    exp_t x;
    x.b = b; x.ovr = ovr;
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_pulse();
    @(posedge clk); #1 uart_clear = 1'b1;
    @(posedge clk); #1 uart_clear = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: a new byte is signalled by byte_ready rising or the byte changing while ready.
  always @(negedge clk) begin
    if (framing_err) n_ferr++;
    if (!rst && byte_ready && (!p_ready || rx_byte != p_byte)) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_byte: got %0h expected none", rx_byte);
      end else begin
        e = sb.pop_front();
        chk("sb_byte", rx_byte, e.b);
        chk("sb_overrun", 8'(overrun), 8'(e.ovr));
        lat = cyc - t_start;
        n_tests++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
          n_fail++;
          $display("FAIL latency: got %0d expected %0d+/-1", lat, LAT);
        end
      end
    end
    p_ready = byte_ready;
    p_byte  = rx_byte;
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_byte", rx_byte, 8'h00);
    chk("rst_ready", 8'(byte_ready), 8'd0);
    chk("rst_ferr", 8'(framing_err), 8'd0);
    chk("rst_ovr", 8'(overrun), 8'd0);
    chk("rst_busy", 8'(rx_busy), 8'd0);
    #1 rst = 1'b0;
    idle(4);

    // Single byte, then consumer clear
    push(8'h32, 1'b0);
    send_frame(8'h32, 1'b1);
    idle(8);
    @(negedge clk);
    chk("b32_ready", 8'(byte_ready), 8'd1);
    chk("b32_byte", rx_byte, 8'h32);
    clear_pulse();
    chk("b32_clr_ready", 8'(byte_ready), 8'd0);

    // Overrun: second byte lands while first is unconsumed
    push(8'h05, 1'b0);
    send_frame(8'h05, 1'b1);
    idle(4);
    push(8'h64, 1'b1);
    send_frame(8'h64, 1'b1);
    idle(4);
    @(negedge clk);
    chk("ovr_byte", rx_byte, 8'h64);
    chk("ovr_ready", 8'(byte_ready), 8'd1);
    chk("ovr_flag", 8'(overrun), 8'd1);
    clear_pulse();
    chk("ovr_clr_ready", 8'(byte_ready), 8'd0);
    chk("ovr_clr_flag", 8'(overrun), 8'd0);

    // Framing error followed by a 40-cycle break
    send_frame(8'hA5, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("fe_busy_low_line", 8'(rx_busy), 8'd1);
    chk("fe_ready", 8'(byte_ready), 8'd0);
    chk("fe_pulses", 8'(n_ferr), 8'd1);
    #1 rx = 1'b1;
    idle(6);
    @(negedge clk);
    chk("fe_busy_after", 8'(rx_busy), 8'd0);

    // 5-cycle glitch is a false start
    @(posedge clk); #1 rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    idle(20);
    @(negedge clk);
    chk("gl_busy", 8'(rx_busy), 8'd0);
    chk("gl_ready", 8'(byte_ready), 8'd0);
    push(8'h33, 1'b0);
    send_frame(8'h33, 1'b1);
    idle(4);
    @(negedge clk);
    chk("gl_b33", rx_byte, 8'h33);
    clear_pulse();

    // Reset pulse during data bit 4 aborts the frame
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(posedge clk);
        repeat (87) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    idle(10);
    @(negedge clk);
    chk("rs_ready", 8'(byte_ready), 8'd0);
    chk("rs_busy", 8'(rx_busy), 8'd0);
    push(8'h65, 1'b0);
    send_frame(8'h65, 1'b1);
    idle(4);
    @(negedge clk);
    chk("rs_b65", rx_byte, 8'h65);

    // Clear on the exact completion cycle: new byte wins, no overrun
    push(8'h55, 1'b0);   // 0x65 is still pending, so 0x55 overwrites it first
    sb[sb.size()-1].ovr = 1'b1;
    send_frame(8'h55, 1'b1);
    idle(4);
    clear_pulse();
    push(8'h44, 1'b0);
    send_frame(8'h44, 1'b1);
    idle(4);
    push(8'h66, 1'b0);
    fork
      send_frame(8'h66, 1'b1);
      begin
        @(posedge clk);
        repeat (LAT - 1) @(posedge clk);
        #1 uart_clear = 1'b1;
        @(posedge clk);
        #1 uart_clear = 1'b0;
      end
    join
    idle(4);
    @(negedge clk);
    chk("cc_byte", rx_byte, 8'h66);
    chk("cc_ready", 8'(byte_ready), 8'd1);
    chk("cc_ovr", 8'(overrun), 8'd0);

    // Nothing left unmatched, no stray framing pulses
    idle(4);
    chk("sb_empty", 8'(sb.size()), 8'd0);
    chk("ferr_total", 8'(n_ferr), 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
